edge_mem_sched: RTL and testbench
=================================

Name: edge_mem_sched

Overview:
- Sequences the edge-detection write-back path and shares the single memory master port between two requesters:
  - the read requester that fetches source pixels for the 3x3 window buffer;
  - the output buffer that drains nine 32-bit processed pixels.
- Generates raster write addresses, issues one memory transaction at a time and returns a one-cycle write-complete pulse to the output buffer.
- Counts written pixels and signals frame done.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, memory data width; matches the output buffer word {gray,gray,gray,8'h00}.
- CNT_W, 20, pixel counter width.
- ADDR_STEP, 4, byte increment between consecutive output pixels.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle pulse; latch base/count, begin frame
- i_dst_base  in  ADDR_W  first output pixel address
- i_pixel_count  in  CNT_W  output pixels in frame
- i_rd_req  in  1  read requester wants a word; held until o_rd_done
- i_rd_addr  in  ADDR_W  read address, stable while i_rd_req
- o_rd_data  out  DATA_W  read data, valid with o_rd_done
- o_rd_done  out  1  one-cycle read completion pulse
- i_write_enable  in  1  output buffer holds a pixel to write
- i_buffer2_data  in  DATA_W  pixel word from output buffer
- o_write_complete  out  1  one-cycle pulse; buffer advances to next pixel
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- o_mem_read  out  1  read strobe
- o_mem_write  out  1  write strobe
- i_mem_busy  in  1  memory stall; a strobe is accepted on a clk edge where i_mem_busy=0
- i_mem_rdata  in  DATA_W  read data, valid on the acceptance edge
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse after last pixel written

Behaviour:
- Reset (asynchronous, n_rst=0): all outputs 0, state IDLE, write address 0, pixel count 0, round-robin pointer = read, running flag 0. Reset mid-transaction aborts the transaction without any completion pulse.
- State IDLE→GRANT always. IDLE performs no memory access.
- Frame control:
  - i_start while o_busy=0 latches i_dst_base into the write-address register, latches i_pixel_count, sets running, and clears the written counter.
  - i_start while o_busy=1 is ignored.
  - i_pixel_count=0: o_done pulses the cycle after i_start and running never sets.
- GRANT: candidates are reads (i_rd_req=1) and writes (running=1, i_write_enable=1, holdoff=0).
  - One candidate → grant it.
  - Both → round-robin: the grant goes to the side not served last, and the pointer updates on each grant.
  - Neither → stay in GRANT.
- RD: o_mem_read=1, o_mem_addr=i_rd_addr. On acceptance, register i_mem_rdata to o_rd_data, pulse o_rd_done next cycle, return to GRANT.
- WR: o_mem_write=1, o_mem_addr=write address, o_mem_wdata=i_buffer2_data, with addr/data captured at grant and held stable while busy. On acceptance:
  - pulse o_write_complete next cycle;
  - write address += ADDR_STEP, with wrap modulo 2^ADDR_W;
  - written counter +1;
  - holdoff=1 for the cycle of the pulse plus one more, because the buffer updates registered, so the stale i_write_enable is not resampled.
- Frame end: when written == latched count, running clears and o_done pulses in the same cycle as the final o_write_complete. o_busy=running.
- Latency: grant-to-strobe 1 cycle. Minimum read is 3 cycles request→o_rd_done. Back-to-back writes are spaced at least 4 cycles apart.
- Strobe rules: o_mem_read and o_mem_write are never both 1. A strobe, once raised, stays up until accepted.
- Holdoff blocks writes only; reads are still served, so reads proceed during write holdoff.

Optional Feature:
- Macro EDGE_MEM_SCHED_PERF_EN.
- Defined: adds outputs o_stall_cycles and o_wr_cycles (32 bits each, saturating).
  - o_stall_cycles counts cycles with a strobe high and i_mem_busy=1.
  - o_wr_cycles counts accepted writes.
  - Both counters clear on reset and on an accepted i_start.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package edge_pkg: sched_state_t enum {IDLE, GRANT, RD, WR}, PIXEL_WORD_W=32, default ADDR_STEP.
- One sub-module, rr_arb2: two-request round-robin arbiter with a registered last-grant pointer. It is reusable for the read-side window buffer.

Test Plan:
- Reset: n_rst low mid-WR with i_mem_busy=1 → all outputs 0, and no o_write_complete after release.
- Single frame: i_dst_base=0x1000, i_pixel_count=9, i_write_enable held 1, i_mem_busy=0 → 9 writes at 0x1000..0x1020 step 4, 9 o_write_complete pulses, o_done with the 9th.
- Stall: i_mem_busy=1 for 5 cycles on the 2nd write → addr/wdata held stable, exactly one o_write_complete.
- Contention: i_rd_req and i_write_enable both continuously 1 → grants alternate R,W,R,W; o_rd_data equals i_mem_rdata 0xDEADBEEF.
- Boundary: i_pixel_count=0 → o_done one cycle after i_start, no o_mem_write. i_start while busy → ignored, counts unchanged.
- Wrap: i_dst_base=0xFFFFFFFC, count 2 → addresses 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/edge_pkg.sv
// edge_pkg: shared scheduler state encoding and pixel/address constants for the edge write-back path.
package edge_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, RD, WR} sched_state_t;
  localparam int PIXEL_WORD_W = 32;
  localparam int ADDR_STEP    = 4;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin arbiter; ptr_q names the side preferred on the next tie (0 = req_i[0]).
module rr_arb2 (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic ptr_q;
  always_comb gnt_o = &req_i ? (ptr_q ? 2'b10 : 2'b01) : req_i;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) ptr_q <= 1'b0;
    else if (en_i && |req_i) ptr_q <= gnt_o[0];
endmodule

// File: rtl/edge_mem_sched.sv
// edge_mem_sched: shares one memory master port between window-buffer reads and raster pixel writes.
// Optional EDGE_MEM_SCHED_PERF_EN adds saturating stall / accepted-write counters.
module edge_mem_sched
  import edge_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = PIXEL_WORD_W,
  parameter int CNT_W     = 20,
  parameter int ADDR_STEP = edge_pkg::ADDR_STEP
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_dst_base,
  input  logic [CNT_W-1:0]  i_pixel_count,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_done,
  input  logic              i_write_enable,
  input  logic [DATA_W-1:0] i_buffer2_data,
  output logic              o_write_complete,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic              i_mem_busy,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
`ifdef EDGE_MEM_SCHED_PERF_EN
  output logic [31:0]       o_stall_cycles,
  output logic [31:0]       o_wr_cycles,
`endif
  output logic              o_done
);
  sched_state_t      state_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [CNT_W-1:0]  count_q, written_q;
  logic              running_q;
  logic [1:0]        hold_q;
  logic [1:0]        gnt;
  logic              rd_cand, wr_cand, start_acc, wr_acc;
  // a request still high during its own rd_done pulse is stale, not a new read
  always_comb begin
    rd_cand   = i_rd_req & ~o_rd_done;
    wr_cand   = running_q & i_write_enable & ~|hold_q;
    start_acc = i_start & ~running_q;
    wr_acc    = (state_q == WR) & ~i_mem_busy;
  end
  assign o_busy = running_q;
  rr_arb2 u_arb (
    .clk   (clk),
    .n_rst (n_rst),
    .en_i  (state_q == GRANT),
    .req_i ({wr_cand, rd_cand}),
    .gnt_o (gnt)
  );
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q          <= IDLE;
      waddr_q          <= '0;
      count_q          <= '0;
      written_q        <= '0;
      running_q        <= 1'b0;
      hold_q           <= '0;
      o_rd_data        <= '0;
      o_rd_done        <= 1'b0;
      o_write_complete <= 1'b0;
      o_mem_addr       <= '0;
      o_mem_wdata      <= '0;
      o_mem_read       <= 1'b0;
      o_mem_write      <= 1'b0;
      o_done           <= 1'b0;
    end else begin
      o_rd_done        <= 1'b0;
      o_write_complete <= 1'b0;
      o_done           <= 1'b0;
      hold_q           <= hold_q >> 1;
      if (start_acc) begin
        waddr_q   <= i_dst_base;
        count_q   <= i_pixel_count;
        written_q <= '0;
        running_q <= i_pixel_count != '0;
        o_done    <= i_pixel_count == '0;
      end
      case (state_q)
        IDLE: state_q <= GRANT;
        GRANT:
          if (gnt[0]) begin
            state_q    <= RD;
            o_mem_read <= 1'b1;
            o_mem_addr <= i_rd_addr;
          end else if (gnt[1]) begin
            state_q     <= WR;
            o_mem_write <= 1'b1;
            o_mem_addr  <= waddr_q;
            o_mem_wdata <= i_buffer2_data;
          end
        RD:
          if (!i_mem_busy) begin
            state_q    <= GRANT;
            o_mem_read <= 1'b0;
            o_rd_data  <= i_mem_rdata;
            o_rd_done  <= 1'b1;
          end
        WR:
          if (!i_mem_busy) begin
            state_q          <= GRANT;
            o_mem_write      <= 1'b0;
            o_write_complete <= 1'b1;
            hold_q           <= 2'b11;
            waddr_q          <= waddr_q + ADDR_W'(ADDR_STEP);
            written_q        <= written_q + CNT_W'(1);
            if (written_q + CNT_W'(1) == count_q) begin
              running_q <= 1'b0;
              o_done    <= 1'b1;
            end
          end
      endcase
    end
  end
`ifdef EDGE_MEM_SCHED_PERF_EN
  logic stall;
  assign stall = (o_mem_read | o_mem_write) & i_mem_busy;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_stall_cycles <= '0;
      o_wr_cycles    <= '0;
    end else if (start_acc) begin
      o_stall_cycles <= '0;
      o_wr_cycles    <= '0;
    end else begin
      if (stall && !(&o_stall_cycles)) o_stall_cycles <= o_stall_cycles + 32'd1;
      if (wr_acc && !(&o_wr_cycles)) o_wr_cycles <= o_wr_cycles + 32'd1;
    end
  end
`else
  logic unused_wr_acc;
  assign unused_wr_acc = wr_acc;
`endif
endmodule

// File: tb/tb_edge_mem_sched.sv
// tb_edge_mem_sched: scoreboard bench; stimulus pushes expected writes, a negedge monitor compares them.
module tb_edge_mem_sched;
  logic        clk = 0, n_rst = 0;
  logic        i_start = 0, i_rd_req = 0, i_write_enable = 0, i_mem_busy = 0;
  logic [31:0] i_dst_base = 0, i_rd_addr = 0, i_mem_rdata = 0, i_buffer2_data;
  logic [19:0] i_pixel_count = 0;
  logic [31:0] o_rd_data, o_mem_addr, o_mem_wdata;
  logic        o_rd_done, o_write_complete, o_mem_read, o_mem_write, o_busy, o_done;

  edge_mem_sched dut (
    .clk(clk), .n_rst(n_rst), .i_start(i_start), .i_dst_base(i_dst_base),
    .i_pixel_count(i_pixel_count), .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_done(o_rd_done), .i_write_enable(i_write_enable),
    .i_buffer2_data(i_buffer2_data), .o_write_complete(o_write_complete),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .i_mem_busy(i_mem_busy), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int wc_cnt = 0, done_cnt = 0, rd_cnt = 0, wr_starts = 0;
  logic done_wc = 0, prev_stb = 0;
  logic [31:0] wr_addr_q[$], wr_data_q[$];
  logic [7:0]  log_q[$];
  logic [7:0]  buf_idx;
  logic        buf_rst = 1;

  function automatic logic [31:0] word(input logic [7:0] k);
    logic [7:0] g;
    g = 8'h10 + k;
    return {g, g, g, 8'h00};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // output buffer model: advances one pixel per write-complete pulse
  always @(posedge clk)
    if (buf_rst) buf_idx <= 0;
    else if (o_write_complete) buf_idx <= buf_idx + 1;
  assign i_buffer2_data = word(buf_idx);

  always @(negedge clk) begin
    if (n_rst) begin
      if (o_mem_read && o_mem_write) chk("strobe_exclusive", 1, 0);
      if ((o_mem_read || o_mem_write) && !prev_stb) begin
        log_q.push_back(o_mem_read ? 8'd82 : 8'd87);
        if (o_mem_write) wr_starts++;
      end
      if (o_mem_write) begin
        if (wr_addr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          chk("wr_addr", o_mem_addr, wr_addr_q[0]);
          chk("wr_data", o_mem_wdata, wr_data_q[0]);
          if (!i_mem_busy) begin
            wr_addr_q.delete(0);
            wr_data_q.delete(0);
          end
        end
      end
      if (o_mem_read) chk("rd_addr", o_mem_addr, i_rd_addr);
      if (o_rd_done) begin
        rd_cnt++;
        chk("rd_data", o_rd_data, i_mem_rdata);
      end
      if (o_write_complete) wc_cnt++;
      if (o_done) begin
        done_cnt++;
        done_wc = o_write_complete;
      end
      prev_stb = o_mem_read | o_mem_write;
    end else prev_stb = 0;
  end

  task automatic begin_frame(input logic [31:0] base, input int cnt);
    buf_rst = 1;
    tick();
    buf_rst = 0;
    for (int k = 0; k < cnt; k++) begin
      wr_addr_q.push_back(base + 32'(4 * k));
      wr_data_q.push_back(word(8'(k)));
    end
    i_dst_base = base;
    i_pixel_count = 20'(cnt);
    i_start = 1;
    tick();
    i_start = 0;
  endtask

  task automatic wait_done(input int d0, input string nm);
    int n = 0;
    while (done_cnt == d0 && n < 400) begin
      tick();
      n++;
    end
    chk(nm, done_cnt > d0, 1);
  endtask

  task automatic end_frame(input int wc0, input int d0, input int cnt, input string nm);
    wait_done(d0, {nm, "_done_seen"});
    chk({nm, "_wc_count"}, wc_cnt - wc0, cnt);
    chk({nm, "_done_with_last_wc"}, done_wc, 1);
    chk({nm, "_queue_drained"}, wr_addr_q.size(), 0);
    chk({nm, "_busy_clear"}, o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wc0, d0, l0, n, ws0;
    repeat (3) tick();
    chk("reset_strobes", {o_mem_read, o_mem_write, o_rd_done, o_write_complete, o_busy, o_done}, 0);
    chk("reset_data", {o_mem_addr, o_mem_wdata}, 0);
    chk("reset_rd_data", o_rd_data, 0);
    n_rst = 1;
    tick();

    // reset while a write is stalled
    i_write_enable = 1;
    i_mem_busy = 1;
    begin_frame(32'h1000, 9);
    n = 0;
    while (!o_mem_write && n < 20) begin tick(); n++; end
    chk("rst_test_write_seen", o_mem_write, 1);
    tick(); tick();
    #2 n_rst = 0;
    #1 chk("rst_mid_wr_outputs", {o_mem_read, o_mem_write, o_write_complete, o_busy, o_done, o_mem_addr, o_mem_wdata}, 0);
    wr_addr_q.delete();
    wr_data_q.delete();
    i_mem_busy = 0;
    tick(); tick();
    n_rst = 1;
    wc0 = wc_cnt;
    repeat (10) tick();
    chk("rst_no_write_complete", wc_cnt - wc0, 0);
    chk("rst_not_busy", o_busy, 0);

    // clean 9-pixel frame
    wc0 = wc_cnt; d0 = done_cnt;
    begin_frame(32'h1000, 9);
    chk("frame_a_busy", o_busy, 1);
    end_frame(wc0, d0, 9, "frame_a");

    // stall on the 2nd write plus an ignored restart
    wc0 = wc_cnt; d0 = done_cnt;
    begin_frame(32'h3000, 9);
    n = 0;
    while (wc_cnt == wc0 && n < 50) begin tick(); n++; end
    chk("stall_first_wc", wc_cnt - wc0, 1);
    i_mem_busy = 1;
    i_dst_base = 32'h5000;
    i_pixel_count = 3;
    i_start = 1;
    tick();
    i_start = 0;
    chk("start_while_busy_ignored", o_busy, 1);
    n = 0;
    for (int t = 0; t < 50 && n < 5; t++) begin
      tick();
      if (o_mem_write) n++;
    end
    chk("stall_cycles_seen", n, 5);
    chk("stall_no_wc", wc_cnt - wc0, 1);
    tick();
    i_mem_busy = 0;
    end_frame(wc0, d0, 9, "frame_b");

    // contention: reads and writes both always pending
    wc0 = wc_cnt; d0 = done_cnt; l0 = log_q.size();
    i_rd_addr = 32'h8000;
    i_mem_rdata = 32'hDEADBEEF;
    i_rd_req = 1;
    begin_frame(32'h2000, 3);
    end_frame(wc0, d0, 3, "contend");
    i_rd_req = 0;
    repeat (4) tick();
    if (log_q.size() >= l0 + 6)
      for (int i = 0; i < 6; i++) chk("grant_order", log_q[l0 + i], (i % 2) ? 8'd87 : 8'd82);
    else chk("grant_count", log_q.size(), l0 + 6);
    chk("contend_reads", rd_cnt >= 3, 1);

    // zero-pixel frame
    d0 = done_cnt; ws0 = wr_starts;
    i_pixel_count = 0;
    i_dst_base = 32'h4000;
    i_start = 1;
    tick();
    i_start = 0;
    chk("zero_done_pulse", o_done, 1);
    chk("zero_not_busy", o_busy, 0);
    repeat (10) tick();
    chk("zero_no_writes", wr_starts - ws0, 0);
    chk("zero_done_once", done_cnt - d0, 1);

    // address wrap
    wc0 = wc_cnt; d0 = done_cnt;
    begin_frame(32'hFFFF_FFFC, 2);
    end_frame(wc0, d0, 2, "wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
